// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the ID/EX hazard controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int WAIT_CNT_W  = 8;
    localparam int FLUSH_CNT_W = 3;

    localparam logic [REG_IDX_W-1:0] c_reg_x0 = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } hz_state_e;

    // A source operand depends on a producer only if it is read and the producer writes a real register.
    function automatic logic reg_match(
        input logic                 use_rs,
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rd
    );
        return use_rs && (rd != c_reg_x0) && (rd == rs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_detect.sv
// ============================================================================
// Module      : hazard_fwd_detect
// Description : Combinational forwarding-select and load-use detection.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_RegWrite,
    input  logic                 ex_MemRead,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_RegWrite,
    output logic                 fwd_ex_1,
    output logic                 fwd_mem_1,
    output logic                 fwd_ex_2,
    output logic                 fwd_mem_2,
    output logic                 load_use
);

    logic w_ex_hit_1;
    logic w_ex_hit_2;
    logic w_mem_hit_1;
    logic w_mem_hit_2;

    assign w_ex_hit_1  = reg_match(id_use_rs1, id_rs1, ex_rd);
    assign w_ex_hit_2  = reg_match(id_use_rs2, id_rs2, ex_rd);
    assign w_mem_hit_1 = reg_match(id_use_rs1, id_rs1, mem_rd);
    assign w_mem_hit_2 = reg_match(id_use_rs2, id_rs2, mem_rd);

    // A load in EX has no data yet, so it never forwards from EX.
    assign fwd_ex_1  = w_ex_hit_1 & ex_RegWrite & ~ex_MemRead;
    assign fwd_ex_2  = w_ex_hit_2 & ex_RegWrite & ~ex_MemRead;
    assign fwd_mem_1 = w_mem_hit_1 & mem_RegWrite & ~fwd_ex_1;
    assign fwd_mem_2 = w_mem_hit_2 & mem_RegWrite & ~fwd_ex_2;

    assign load_use  = ex_MemRead & (w_ex_hit_1 | w_ex_hit_2);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller: forwarding, load-use bubble,
//               branch flush and data-memory wait with timeout watchdog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int WAIT_MAX     = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_RegWrite,
    input  logic                 ex_MemRead,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_RegWrite,
    input  logic                 branch_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 fwd_ex_1,
    output logic                 fwd_mem_1,
    output logic                 fwd_ex_2,
    output logic                 fwd_mem_2,
    output logic                 pc_stall,
    output logic                 if_stall,
    output logic                 if_clear,
    output logic                 id_clear,
    output logic                 pipe_hold,
    output logic                 timeout_err,
    output logic [1:0]           state
);

    localparam logic [FLUSH_CNT_W-1:0] c_flush_full = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [FLUSH_CNT_W-1:0] c_flush_rest = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0]  c_wait_max   = WAIT_CNT_W'(WAIT_MAX);
    localparam logic [WAIT_CNT_W-1:0]  c_wait_sat   = '1;

    hz_state_e              state_q,       state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q,   flush_cnt_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;
    logic                   pend_flush_q,  pend_flush_d;
    logic                   timeout_err_q, timeout_err_d;

    logic w_fwd_ex_1;
    logic w_fwd_mem_1;
    logic w_fwd_ex_2;
    logic w_fwd_mem_2;
    logic w_load_use;
    logic w_mem_stall;

    logic w_pc_stall;
    logic w_if_stall;
    logic w_if_clear;
    logic w_id_clear;
    logic w_pipe_hold;

    hazard_fwd_detect u_fwd_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_RegWrite  (ex_RegWrite),
        .ex_MemRead   (ex_MemRead),
        .mem_rd       (mem_rd),
        .mem_RegWrite (mem_RegWrite),
        .fwd_ex_1     (w_fwd_ex_1),
        .fwd_mem_1    (w_fwd_mem_1),
        .fwd_ex_2     (w_fwd_ex_2),
        .fwd_mem_2    (w_fwd_mem_2),
        .load_use     (w_load_use)
    );

    assign w_mem_stall = dmem_req & ~dmem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            pend_flush_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            pend_flush_q  <= pend_flush_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pend_flush_d  = pend_flush_q;
        timeout_err_d = timeout_err_q;
        w_pc_stall    = 1'b0;
        w_if_stall    = 1'b0;
        w_if_clear    = 1'b0;
        w_id_clear    = 1'b0;
        w_pipe_hold   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_pipe_hold = 1'b1;
                    state_d     = ST_MEM_WAIT;
                    wait_cnt_d  = WAIT_CNT_W'(1);
                    // The deferred branch never issued its own clear, so it needs the full length later.
                    if (branch_taken) begin
                        pend_flush_d = 1'b1;
                        flush_cnt_d  = c_flush_full;
                    end
                end else if (branch_taken) begin
                    w_if_clear = 1'b1;
                    w_id_clear = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = c_flush_rest;
                    end
                end else if (w_load_use) begin
                    w_pc_stall = 1'b1;
                    w_if_stall = 1'b1;
                    w_id_clear = 1'b1;
                end
            end

            ST_FLUSH: begin
                w_if_clear = 1'b1;
                w_id_clear = 1'b1;
                if (w_mem_stall) begin
                    w_pipe_hold  = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = WAIT_CNT_W'(1);
                    pend_flush_d = 1'b1;
                    if (branch_taken) begin
                        flush_cnt_d = c_flush_full;
                    end
                end else if (branch_taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = c_flush_rest;
                    end else begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end
                end else if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                end
            end

            ST_MEM_WAIT: begin
                w_pipe_hold = 1'b1;
                w_pc_stall  = 1'b1;
                w_if_stall  = 1'b1;
                if (branch_taken) begin
                    pend_flush_d = 1'b1;
                    flush_cnt_d  = c_flush_full;
                end
                if (dmem_ack) begin
                    pend_flush_d = 1'b0;
                    wait_cnt_d   = '0;
                    if (pend_flush_q || branch_taken) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end
                end else if (wait_cnt_q >= c_wait_max) begin
                    state_d       = ST_HALT;
                    timeout_err_d = 1'b1;
                end else if (wait_cnt_q != c_wait_sat) begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end

            ST_HALT: begin
                w_pipe_hold = 1'b1;
                w_pc_stall  = 1'b1;
                w_if_stall  = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are forced low combinationally so they drop the moment reset asserts.
    assign fwd_ex_1    = w_fwd_ex_1  & rst;
    assign fwd_mem_1   = w_fwd_mem_1 & rst;
    assign fwd_ex_2    = w_fwd_ex_2  & rst;
    assign fwd_mem_2   = w_fwd_mem_2 & rst;
    assign pc_stall    = w_pc_stall  & rst;
    assign if_stall    = w_if_stall  & rst;
    assign if_clear    = w_if_clear  & rst;
    assign id_clear    = w_id_clear  & rst;
    assign pipe_hold   = w_pipe_hold & rst;
    assign timeout_err = timeout_err_q & rst;
    assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, ex_RegWrite, ex_MemRead, mem_RegWrite;
    logic       branch_taken, dmem_req, dmem_ack;

    logic       fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2;
    logic       pc_stall, if_stall, if_clear, id_clear, pipe_hold, timeout_err;
    logic [1:0] state;

    logic       f1_fwd_ex_1, f1_fwd_mem_1, f1_fwd_ex_2, f1_fwd_mem_2;
    logic       f1_pc_stall, f1_if_stall, f1_if_clear, f1_id_clear, f1_pipe_hold, f1_timeout_err;
    logic [1:0] f1_state;

    logic [3:0]  fwd;
    logic [4:0]  ctl;
    logic [11:0] all_out;
    logic [3:0]  f1_fwd;
    logic [4:0]  f1_ctl;

    int n_vec = 0;
    int n_err = 0;

    assign fwd     = {fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2};
    assign ctl     = {pipe_hold, pc_stall, if_stall, if_clear, id_clear};
    assign all_out = {fwd, ctl, timeout_err, state};
    assign f1_fwd  = {f1_fwd_ex_1, f1_fwd_mem_1, f1_fwd_ex_2, f1_fwd_mem_2};
    assign f1_ctl  = {f1_pipe_hold, f1_pc_stall, f1_if_stall, f1_if_clear, f1_id_clear};

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .WAIT_MAX(15)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .fwd_ex_1(fwd_ex_1), .fwd_mem_1(fwd_mem_1), .fwd_ex_2(fwd_ex_2), .fwd_mem_2(fwd_mem_2),
        .pc_stall(pc_stall), .if_stall(if_stall), .if_clear(if_clear), .id_clear(id_clear),
        .pipe_hold(pipe_hold), .timeout_err(timeout_err), .state(state)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .WAIT_MAX(15)) u_dut_f1 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .fwd_ex_1(f1_fwd_ex_1), .fwd_mem_1(f1_fwd_mem_1), .fwd_ex_2(f1_fwd_ex_2), .fwd_mem_2(f1_fwd_mem_2),
        .pc_stall(f1_pc_stall), .if_stall(f1_if_stall), .if_clear(f1_if_clear), .id_clear(f1_id_clear),
        .pipe_hold(f1_pipe_hold), .timeout_err(f1_timeout_err), .state(f1_state)
    );

    task automatic drive_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0;
        mem_rd = 5'd0; mem_RegWrite = 1'b0;
        branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_rd = 5'd5; ex_RegWrite = 1'b1;
        branch_taken = 1'b1; dmem_req = 1'b1;
        #1;
        n_vec++;
        if (all_out !== 12'd0) begin
            n_err++; $display("FAIL reset_outputs got %b exp %b", all_out, 12'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        n_vec++;
        if (all_out !== 12'd0) begin
            n_err++; $display("FAIL reset_release got %b exp %b", all_out, 12'd0);
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        drive_idle();
        ex_rd = 5'd5; ex_RegWrite = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        mem_rd = 5'd5; mem_RegWrite = 1'b1;
        #1;
        n_vec++;
        if (fwd !== 4'b1000 || ctl !== 5'd0) begin
            n_err++; $display("FAIL fwd_ex_priority got fwd=%b ctl=%b exp fwd=1000 ctl=00000", fwd, ctl);
        end
        @(negedge clk);
        ex_rd = 5'd0;
        #1;
        n_vec++;
        if (fwd !== 4'b0100) begin
            n_err++; $display("FAIL fwd_mem_x0 got %b exp 0100", fwd);
        end
        @(negedge clk);
        id_use_rs1 = 1'b0;
        #1;
        n_vec++;
        if (fwd !== 4'b0000) begin
            n_err++; $display("FAIL fwd_no_use got %b exp 0000", fwd);
        end
        @(negedge clk);
        drive_idle();
        ex_rd = 5'd3; ex_RegWrite = 1'b1; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        mem_rd = 5'd3; mem_RegWrite = 1'b1; id_rs1 = 5'd3;
        #1;
        n_vec++;
        if (fwd !== 4'b0010 || f1_fwd !== 4'b0010) begin
            n_err++; $display("FAIL fwd_ex_2 got %b/%b exp 0010", fwd, f1_fwd);
        end
        @(negedge clk);
        ex_RegWrite = 1'b0;
        #1;
        n_vec++;
        if (fwd !== 4'b0001) begin
            n_err++; $display("FAIL fwd_mem_2 got %b exp 0001", fwd);
        end
        @(negedge clk);
        mem_rd = 5'd4;
        #1;
        n_vec++;
        if (fwd !== 4'b0000) begin
            n_err++; $display("FAIL fwd_mem_mismatch got %b exp 0000", fwd);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive_idle();
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 5'b01101 || fwd !== 4'b0000 || state !== 2'd0) begin
            n_err++; $display("FAIL load_use_stall got ctl=%b fwd=%b st=%0d exp ctl=01101 fwd=0000 st=0", ctl, fwd, state);
        end
        @(negedge clk);
        ex_MemRead = 1'b0; ex_RegWrite = 1'b0; ex_rd = 5'd0;
        mem_rd = 5'd7; mem_RegWrite = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 5'b00000 || fwd !== 4'b0001 || state !== 2'd0) begin
            n_err++; $display("FAIL load_use_after got ctl=%b fwd=%b st=%0d exp ctl=00000 fwd=0001 st=0", ctl, fwd, state);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        drive_idle();
        branch_taken = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 5'b00011 || state !== 2'd0 || f1_ctl !== 5'b00011 || f1_state !== 2'd0) begin
            n_err++; $display("FAIL branch_c0 got %b/%0d f1 %b/%0d exp 00011/0 f1 00011/0", ctl, state, f1_ctl, f1_state);
        end
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 5'b00011 || state !== 2'd1 || f1_ctl !== 5'b00000 || f1_state !== 2'd0) begin
            n_err++; $display("FAIL branch_c1 got %b/%0d f1 %b/%0d exp 00011/1 f1 00000/0", ctl, state, f1_ctl, f1_state);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (ctl !== 5'b00000 || state !== 2'd0) begin
            n_err++; $display("FAIL branch_c2 got %b/%0d exp 00000/0", ctl, state);
        end
    endtask

    task automatic test_branch_load_use();
        @(negedge clk);
        drive_idle();
        branch_taken = 1'b1;
        ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 5'b00011) begin
            n_err++; $display("FAIL branch_over_load_use got %b exp 00011", ctl);
        end
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 5'b00011 || state !== 2'd1) begin
            n_err++; $display("FAIL flush_ignores_load_use got %b/%0d exp 00011/1", ctl, state);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_vec++;
        if (ctl !== 5'b00000 || state !== 2'd0) begin
            n_err++; $display("FAIL branch_lu_done got %b/%0d exp 00000/0", ctl, state);
        end
    endtask

    task automatic test_mem_wait();
        logic [4:0] exp_ctl [8];
        logic [1:0] exp_st  [8];
        exp_ctl = '{5'b10000, 5'b11100, 5'b11100, 5'b11100, 5'b11100, 5'b00011, 5'b00011, 5'b00000};
        exp_st  = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_idle();
            dmem_req     = (i <= 4);
            dmem_ack     = (i == 4);
            branch_taken = (i == 0);
            if (i == 2) begin
                ex_rd = 5'd9; ex_RegWrite = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
            end
            #1;
            n_vec++;
            if (ctl !== exp_ctl[i] || state !== exp_st[i] || fwd !== ((i == 2) ? 4'b1000 : 4'b0000)) begin
                n_err++; $display("FAIL mem_wait_c%0d got ctl=%b st=%0d fwd=%b exp ctl=%b st=%0d", i, ctl, state, fwd, exp_ctl[i], exp_st[i]);
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        drive_idle();
        dmem_req = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 5'b10000 || state !== 2'd0) begin
            n_err++; $display("FAIL timeout_enter got %b/%0d exp 10000/0", ctl, state);
        end
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (state !== 2'd2 || timeout_err !== 1'b0 || ctl !== 5'b11100) begin
                n_err++; $display("FAIL timeout_wait_%0d got st=%0d err=%b ctl=%b exp st=2 err=0 ctl=11100", i, state, timeout_err, ctl);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dmem_req = 1'b0;
            #1;
            n_vec++;
            if (state !== 2'd3 || timeout_err !== 1'b1 || ctl !== 5'b11100 || f1_timeout_err !== 1'b1) begin
                n_err++; $display("FAIL halt_%0d got st=%0d err=%b/%b ctl=%b exp st=3 err=1 ctl=11100", i, state, timeout_err, f1_timeout_err, ctl);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (all_out !== 12'd0) begin
            n_err++; $display("FAIL halt_async_reset got %b exp %b", all_out, 12'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (all_out !== 12'd0) begin
            n_err++; $display("FAIL halt_reset_release got %b exp %b", all_out, 12'd0);
        end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        drive_idle();
        branch_taken = 1'b1;
        #1;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 5'b00011 || state !== 2'd1) begin
            n_err++; $display("FAIL mid_flush got %b/%0d exp 00011/1", ctl, state);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (all_out !== 12'd0) begin
            n_err++; $display("FAIL flush_async_reset got %b exp %b", all_out, 12'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (all_out !== 12'd0) begin
            n_err++; $display("FAIL flush_reset_release got %b exp %b", all_out, 12'd0);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion exp completion within 100000 time units");
        $fatal(1, "bench watchdog expired");
    end

endmodule

`default_nettype wire
